// File: rtl/vol_pkg.sv
// Shared definitions for the volume display path. Both the level
// measurement stage and the bar/display stage import this package.
//
// Contents:
//   SAMPLE_W     - mic sample width in bits
//   LEVEL_W      - volume level width in bits
//   LEVEL_MAX    - largest volume level that can be shown
//   BASELINE_DEF - default mic mid-scale code
package vol_pkg;

    localparam int SAMPLE_W     = 12;
    localparam int LEVEL_W      = 4;
    localparam int LEVEL_MAX    = 15;
    localparam int BASELINE_DEF = 2048;

endpackage

// File: rtl/vol_quant.sv
// Combinational quantiser. Turns a peak amplitude into a volume level:
// level = min(LEVEL_MAX, pk >> STEP_LOG2).
//
// Parameters:
//   STEP_LOG2 - log2 of the number of amplitude codes per level step
// Ports:
//   pk    in  SAMPLE_W  peak amplitude
//   level out LEVEL_W   saturated level, 0..LEVEL_MAX
module vol_quant
    import vol_pkg::*;
#(
    parameter int STEP_LOG2 = 7
) (
    input  logic [SAMPLE_W-1:0] pk,
    output logic [LEVEL_W-1:0]  level
);

    logic [SAMPLE_W-1:0] shifted;

    assign shifted = pk >> STEP_LOG2;

    // Compare all shifted bits, so large peaks clamp to the top level
    // and do not wrap around in the narrow output.
    assign level = (shifted > SAMPLE_W'(LEVEL_MAX)) ? LEVEL_W'(LEVEL_MAX)
                                                    : shifted[LEVEL_W-1:0];

endmodule

// File: rtl/vol_level.sv
// Volume level measurement. Tracks the peak amplitude above the baseline
// over a window of WINDOW sample strobes. At the end of each window it
// publishes a quantised 4-bit level on num. The level is registered and
// held until the next publish.
//
// Optional feature: define VOL_LEVEL_SMOOTH_EN to make falls slower.
// With it, a falling level moves num down by one step per publish.
// Rises still take effect at once.
//
// Parameters:
//   WINDOW    - samples per window (2..65535)
//   BASELINE  - mic mid-scale code; samples at or below it give amplitude 0
//   STEP_LOG2 - log2 of amplitude codes per level step
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   synchronous reset, active high
//   sample_en in   1   one-cycle strobe; mic_in is valid while it is high
//   mic_in    in  12   unsigned mic sample
//   hold      in   1   freezes num; only sampled in the publish cycle
//   num       out  4   volume level 0..15
//   num_valid out  1   one-cycle pulse when num is written
//   peak      out 12   peak amplitude of the last completed window
module vol_level
    import vol_pkg::*;
#(
    parameter int WINDOW    = 4000,
    parameter int BASELINE  = BASELINE_DEF,
    parameter int STEP_LOG2 = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic [SAMPLE_W-1:0] mic_in,
    input  logic                hold,
    output logic [LEVEL_W-1:0]  num,
    output logic                num_valid,
    output logic [SAMPLE_W-1:0] peak
);

    localparam logic [SAMPLE_W-1:0] BASE     = SAMPLE_W'(BASELINE);
    localparam logic [15:0]         CNT_LAST = 16'(WINDOW - 1);

    logic [15:0]         cnt;
    logic [SAMPLE_W-1:0] pk_acc;
    logic [SAMPLE_W-1:0] pk_fin;
    logic                upd;     // high in the single publish cycle

    logic [SAMPLE_W-1:0] amp;
    logic [SAMPLE_W-1:0] pk_max;
    logic [LEVEL_W-1:0]  level;
    logic [LEVEL_W-1:0]  num_next;

    assign amp    = (mic_in > BASE) ? (mic_in - BASE) : '0;
    assign pk_max = (amp > pk_acc) ? amp : pk_acc;

    vol_quant #(
        .STEP_LOG2 (STEP_LOG2)
    ) u_quant (
        .pk    (pk_fin),
        .level (level)
    );

`ifdef VOL_LEVEL_SMOOTH_EN
    // A fall moves num down by one step per publish.
    assign num_next = (level < num) ? (num - LEVEL_W'(1)) : level;
`else
    assign num_next = level;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pk_acc    <= '0;
            pk_fin    <= '0;
            upd       <= 1'b0;
            num       <= '0;
            num_valid <= 1'b0;
            peak      <= '0;
        end else begin
            num_valid <= 1'b0;

            // Publish cycle. Strobes are never back to back, so a close
            // cannot happen in this cycle. Clearing upd here, before the
            // strobe handling, cannot hide a close.
            if (upd) begin
                upd  <= 1'b0;
                peak <= pk_fin;
                if (!hold) begin
                    num       <= num_next;
                    num_valid <= 1'b1;
                end
            end

            if (sample_en) begin
                if (cnt == CNT_LAST) begin
                    // The closing sample is counted in this window's peak.
                    pk_fin <= pk_max;
                    pk_acc <= '0;
                    cnt    <= '0;
                    upd    <= 1'b1;
                end else begin
                    pk_acc <= pk_max;
                    cnt    <= cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vol_level.sv
module tb_vol_level;
    import vol_pkg::*;

    logic                clk;
    logic                rst;
    logic                sample_en;
    logic [SAMPLE_W-1:0] mic_in;
    logic                hold;
    logic [LEVEL_W-1:0]  num;
    logic                num_valid;
    logic [SAMPLE_W-1:0] peak;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int exp_pulses = 0;
    int cur_num = 0;   // model of num

    vol_level #(
        .WINDOW    (4),
        .BASELINE  (2048),
        .STEP_LOG2 (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_en (sample_en),
        .mic_in    (mic_in),
        .hold      (hold),
        .num       (num),
        .num_valid (num_valid),
        .peak      (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (num_valid) pulses <= pulses + 1;

    typedef struct {
        int s0, s1, s2, s3;
        bit hold;
        int exp_peak;
        int exp_level;   // quantised level of exp_peak
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One strobe. Sampled at the next edge. Returns #1 after the third edge.
    task automatic strobe(input int v);
        sample_en = 1'b1;
        mic_in    = SAMPLE_W'(v);
        @(posedge clk); #1;
        sample_en = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task automatic run_window(input vec_t v, input string tag);
        int p0;
        int exp_num;
        bit exp_nv;
        p0 = pulses;
        hold = v.hold;
        strobe(v.s0);
        strobe(v.s1);
        strobe(v.s2);
        chk({tag, "_no_early_pulse"}, pulses, p0);
        // Closing strobe.
        sample_en = 1'b1;
        mic_in    = SAMPLE_W'(v.s3);
        @(posedge clk); #1;
        sample_en = 1'b0;
        chk({tag, "_nv_close_cycle"}, int'(num_valid), 0);
        exp_nv = !v.hold;
        if (exp_nv) begin
`ifdef VOL_LEVEL_SMOOTH_EN
            exp_num = (v.exp_level < cur_num) ? cur_num - 1 : v.exp_level;
`else
            exp_num = v.exp_level;
`endif
            cur_num = exp_num;
            exp_pulses++;
        end
        @(posedge clk); #1;
        chk({tag, "_nv_publish"}, int'(num_valid), int'(exp_nv));
        chk({tag, "_num"}, int'(num), cur_num);
        chk({tag, "_peak"}, int'(peak), v.exp_peak);
        @(posedge clk); #1;
        chk({tag, "_nv_after"}, int'(num_valid), 0);
        chk({tag, "_num_held"}, int'(num), cur_num);
    endtask

    initial begin
        vecs[0]  = '{2100, 2500, 2200, 2048, 1'b0,  452,  3};
        vecs[1]  = '{4095, 2048, 2048, 2048, 1'b0, 2047, 15};
        vecs[2]  = '{1000, 1000, 1000, 1000, 1'b0,    0,  0};
        vecs[3]  = '{2048, 2048, 2048, 3072, 1'b0, 1024,  8};
        vecs[4]  = '{2304, 2048, 2048, 2048, 1'b1,  256,  2};
        vecs[5]  = '{2304, 2048, 2048, 2048, 1'b0,  256,  2};
        vecs[6]  = '{2175, 2049, 2048, 2176, 1'b0,  128,  1};
        vecs[7]  = '{2048, 3968, 2048, 2048, 1'b0, 1920, 15};
        vecs[8]  = '{1000, 2048,  500, 2000, 1'b0,    0,  0};
        vecs[9]  = '{1000, 2048,  500, 2000, 1'b0,    0,  0};
        vecs[10] = '{1000, 2048,  500, 2000, 1'b0,    0,  0};
        vecs[11] = '{2100, 3968, 2175, 2049, 1'b0, 1920, 15};

        rst = 1'b1; sample_en = 1'b0; mic_in = '0; hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_num", int'(num), 0);
        chk("rst_peak", int'(peak), 0);
        chk("rst_nv", int'(num_valid), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            run_window(vecs[i], $sformatf("vec%0d", i));

        // Reset during a partial window. The loud samples must be dropped,
        // and the next publish must come only after four new strobes.
        strobe(4095);
        strobe(4095);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_num", int'(num), 0);
        chk("midrst_peak", int'(peak), 0);
        chk("midrst_nv", int'(num_valid), 0);
        cur_num = 0;
        run_window(vecs[0], "post_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("pulse_count", pulses, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
